// File: rtl/fdiv_unit.sv
// rtl/fdiv_unit.sv - two-stage binary32 divider: seeded Newton-Raphson reciprocal then normalising multiply
module fdiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] y
);

    logic        x1_sgn;
    logic        x2_sgn;
    logic [7:0]  x1_exp;
    logic [7:0]  x2_exp;
    logic [22:0] x1_man;
    logic [22:0] x2_man;

    assign {x1_sgn, x1_exp, x1_man} = x1;
    assign {x2_sgn, x2_exp, x2_man} = x2;

    // Reciprocal seed indexed by the top 8 mantissa bits: 1024 / (interval midpoint),
    // so entries lie in (512, 1023] and the seed is good to roughly 9 bits.
    logic [9:0] seed_tab [256];
    for (genvar gi = 0; gi < 256; gi++) begin : g_seed
        assign seed_tab[gi] = 10'((1048576 / (513 + 2 * gi) + 1) / 2);
    end

    // One Newton-Raphson refinement r' = r * (2 - d*r).
    // d is 1.m in Q1.23, r is Q1.30; intermediates are kept wide enough to be exact.
    function automatic logic [31:0] nr_step(input logic [23:0] d, input logic [31:0] r);
        logic [55:0] t_full;
        logic [31:0] t;
        logic [31:0] e;
        logic [63:0] p;
        t_full = 56'(d) * 56'(r);
        t      = 32'(t_full >> 23);
        e      = 32'h8000_0000 - t;
        p      = 64'(r) * 64'(e);
        return 32'(p >> 30);
    endfunction

    // stage-1 state
    logic        vld_q, vld_d;
    logic        s1_q, s1_d;
    logic        s2_q, s2_d;
    logic        z1_q, z1_d;
    logic        i1_q, i1_d;
    logic        z2_q, z2_d;
    logic        i2_q, i2_d;
    logic [7:0]  e1_q, e1_d;
    logic [22:0] m1_q, m1_d;
    logic [9:0]  inv_exp_q, inv_exp_d;
    logic [23:0] rm_q, rm_d;

    // stage-2 state
    logic [31:0] y_q, y_d;

    logic [23:0] d_fx;
    logic [31:0] r0;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [24:0] rm_sum;

    // The reciprocal exponent is kept at 10 bits internally so divisors near the top of
    // the range (whose reciprocal exponent drops to 0 or -1) do not wrap.
    logic [31:0] inv_x2;
    assign inv_x2 = {s2_q, inv_exp_q[7:0], rm_q[22:0]};

    // Stage 1: classify operands and form the reciprocal mantissa of x2 in (1, 2].
    always_comb begin
        d_fx      = {1'b1, x2_man};
        r0        = {2'b00, seed_tab[x2_man[22:15]], 20'd0};
        r1        = nr_step(d_fx, r0);
        r2        = nr_step(d_fx, r1);
        rm_sum    = 25'((r2 + 32'd32) >> 6);
        vld_d     = 1'b1;
        s1_d      = x1_sgn;
        s2_d      = x2_sgn;
        z1_d      = (x1_exp == 8'd0);
        i1_d      = (x1_exp == 8'hFF);
        z2_d      = (x2_exp == 8'd0);
        i2_d      = (x2_exp == 8'hFF);
        e1_d      = x1_exp;
        m1_d      = x1_man;
        rm_d      = rm_sum[24] ? 24'hFF_FFFF : rm_sum[23:0];
        inv_exp_d = 10'd253 - {2'b00, x2_exp};
        if (x2_man == 23'd0) begin
            // power-of-two divisor: reciprocal is exact
            rm_d      = 24'h80_0000;
            inv_exp_d = 10'd254 - {2'b00, x2_exp};
        end
    end

    // Stage-1 pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q     <= 1'b0;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            z1_q      <= 1'b0;
            i1_q      <= 1'b0;
            z2_q      <= 1'b0;
            i2_q      <= 1'b0;
            e1_q      <= 8'd0;
            m1_q      <= 23'd0;
            inv_exp_q <= 10'd0;
            rm_q      <= 24'd0;
        end else begin
            vld_q     <= vld_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            z1_q      <= z1_d;
            i1_q      <= i1_d;
            z2_q      <= z2_d;
            i2_q      <= i2_d;
            e1_q      <= e1_d;
            m1_q      <= m1_d;
            inv_exp_q <= inv_exp_d;
            rm_q      <= rm_d;
        end
    end

    logic [47:0] prod;
    logic [47:0] norm;
    logic [24:0] mant_r;
    logic [9:0]  eb;
    logic [32:0] total;
    logic [9:0]  exp_f;
    logic        res_sign;

    // Stage 2: multiply, normalise by one bit, round to nearest, then resolve specials.
    // The rounded mantissa (hidden bit included) is added onto {exponent-1, 0} so a
    // rounding carry to 2.0 bumps the exponent without a separate adjust.
    always_comb begin
        prod     = 48'({1'b1, m1_q}) * 48'(rm_q);
        norm     = prod[47] ? prod : {prod[46:0], 1'b0};
        mant_r   = 25'(({1'b0, norm} + 49'h80_0000) >> 24);
        eb       = {2'b00, e1_q} + inv_exp_q + {9'd0, prod[47]} - 10'd128;
        total    = {eb, 23'd0} + {8'd0, mant_r};
        exp_f    = total[32:23];
        res_sign = s1_q ^ s2_q;
        y_d      = 32'd0;
        if (!vld_q) begin
            y_d = 32'd0;
        end else if ((z1_q && z2_q) || (i1_q && i2_q)) begin
            y_d = 32'h7FC0_0000;
        end else if (z1_q || i2_q) begin
            y_d = {res_sign, 31'd0};
        end else if (z2_q || i1_q) begin
            y_d = {res_sign, 8'hFF, 23'd0};
        end else if ($signed(exp_f) >= $signed(10'd255)) begin
            y_d = {res_sign, 8'hFF, 23'd0};
        end else if ($signed(exp_f) <= $signed(10'd0)) begin
            y_d = {res_sign, 31'd0};
        end else begin
            y_d = {res_sign, exp_f[7:0], total[22:0]};
        end
    end

    // Stage-2 output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= 32'd0;
        end else begin
            y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_fdiv_unit.sv
// tb/tb_fdiv_unit.sv - directed and randomized bench for fdiv_unit with a real-arithmetic reference
module tb_fdiv_unit;

    logic        clk;
    logic        rst;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] y;

    fdiv_unit dut (
        .clk(clk),
        .rst(rst),
        .x1 (x1),
        .x2 (x2),
        .y  (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // expectation slots: index 0 = driven one cycle ago, index 1 = two cycles ago
    logic [31:0] sl_ye [2];
    logic [31:0] sl_ie [2];
    bit          sl_yx [2];
    bit          sl_yc [2];
    bit          sl_ix [2];
    bit          sl_ic [2];
    string       sl_tg [2];

    logic [31:0] ra, rb, rye, rie;
    bit          ryx, rix, ric;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] expv, input bit exact);
        logic [31:0] dp;
        logic [31:0] dm;
        bit          ok;
        dp = obs - expv;
        dm = expv - obs;
        ok = (obs === expv) ||
             (!exact && !$isunknown(obs) && (obs[31] == expv[31]) && (dp == 32'd1 || dm == 32'd1));
        n_total++;
        assert (ok) n_pass++;
        else $error("FAIL %s: observed %h expected %h%s", tag, obs, expv, exact ? "" : " (+/-1 ulp)");
    endtask

    // One cycle: check what has matured, then drive the next operands.
    task automatic drive(input bit r, input logic [31:0] a, input logic [31:0] b, input string tag,
                         input logic [31:0] ye, input bit yx, input bit yc,
                         input logic [31:0] ie, input bit ix, input bit ic);
        @(negedge clk);
        if (sl_yc[1]) check_val({sl_tg[1], "/y"}, y, sl_ye[1], sl_yx[1]);
        if (sl_ic[0]) check_val({sl_tg[0], "/inv"}, dut.inv_x2, sl_ie[0], sl_ix[0]);
        sl_ye[1] = sl_ye[0]; sl_yx[1] = sl_yx[0]; sl_yc[1] = sl_yc[0];
        sl_ie[1] = sl_ie[0]; sl_ix[1] = sl_ix[0]; sl_ic[1] = sl_ic[0]; sl_tg[1] = sl_tg[0];
        sl_ye[0] = ye; sl_yx[0] = yx; sl_yc[0] = yc;
        sl_ie[0] = ie; sl_ix[0] = ix; sl_ic[0] = ic; sl_tg[0] = tag;
        if (r) begin
            for (int k = 0; k < 2; k++) begin
                sl_ye[k] = 32'd0; sl_yx[k] = 1'b1; sl_yc[k] = 1'b1;
                sl_ie[k] = 32'd0; sl_ix[k] = 1'b1; sl_ic[k] = (k == 0);
                sl_tg[k] = {tag, "_rst"};
            end
        end
        rst = r;
        x1  = a;
        x2  = b;
    endtask

    // Reference quotient from real division, rounded to nearest at 24 bits.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b, output bit exact);
        bit  s, za, ia, zb, ib;
        real q;
        int  e, mi;
        s  = a[31] ^ b[31];
        za = (a[30:23] == 8'd0);
        ia = (a[30:23] == 8'hFF);
        zb = (b[30:23] == 8'd0);
        ib = (b[30:23] == 8'hFF);
        exact = 1'b1;
        if ((za && zb) || (ia && ib)) return 32'h7FC0_0000;
        if (za || ib) return {s, 31'd0};
        if (zb || ia) return {s, 8'hFF, 23'd0};
        q = (1.0 + a[22:0] / 8388608.0) / (1.0 + b[22:0] / 8388608.0);
        e = int'(a[30:23]) - int'(b[30:23]) + 127;
        if (q < 1.0) begin
            q = q * 2.0;
            e = e - 1;
        end
        mi = $rtoi(q * 8388608.0 + 0.5);
        if (mi >= 16777216) begin
            mi = 8388608;
            e  = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        exact = (b[22:0] == 23'd0);
        return {s, 8'(e), mi[22:0]};
    endfunction

    // Reference reciprocal of a normal divisor whose reciprocal exponent fits 8 bits.
    function automatic logic [31:0] ref_inv(input logic [31:0] b, output bit exact);
        real q;
        int  mi;
        if (b[22:0] == 23'd0) begin
            exact = 1'b1;
            return {b[31], 8'(254 - int'(b[30:23])), 23'd0};
        end
        exact = 1'b0;
        q  = 2.0 / (1.0 + b[22:0] / 8388608.0);
        mi = $rtoi(q * 8388608.0 + 0.5);
        return {b[31], 8'(253 - int'(b[30:23])), mi[22:0]};
    endfunction

    function automatic logic [31:0] rnd_op();
        int          c;
        logic [7:0]  e;
        logic [22:0] m;
        c = int'($urandom_range(0, 11));
        m = 23'($urandom);
        if (c == 0)      e = 8'd0;
        else if (c == 1) e = 8'hFF;
        else             e = 8'($urandom_range(70, 180));
        if (c == 2) m = 23'd0;
        return {1'($urandom), e, m};
    endfunction

    initial begin
        rst = 1'b1;
        x1  = 32'd0;
        x2  = 32'd0;
        for (int k = 0; k < 2; k++) begin
            sl_yc[k] = 1'b0;
            sl_ic[k] = 1'b0;
        end

        drive(1, 32'd0, 32'd0, "init", 32'd0, 1, 0, 32'd0, 1, 0);
        drive(1, 32'd0, 32'd0, "init", 32'd0, 1, 0, 32'd0, 1, 0);

        drive(0, 32'h4040_0000, 32'h4000_0000, "3/2",     32'h3FC0_0000, 1, 1, 32'h3F00_0000, 1, 1);
        drive(0, 32'h4048_F5C3, 32'h4000_0000, "3.14/2",  32'h3FC8_F5C3, 1, 1, 32'h3F00_0000, 1, 1);
        drive(0, 32'h437F_0000, 32'hC37F_0000, "255/-255",32'hBF80_0000, 0, 1, 32'hBB80_8081, 0, 1);
        drive(0, 32'h3F80_0000, 32'h3F8C_CCCD, "1/1.1",   32'h3F68_BA2F, 0, 1, 32'h3F68_BA2F, 0, 1);
        drive(0, 32'h4020_0000, 32'h4000_0000, "2.5/2",   32'h3FA0_0000, 1, 1, 32'h3F00_0000, 1, 1);
        drive(0, 32'h7F0C_CCCD, 32'h7E99_999A, "bigexp",  32'h3FEA_AAAB, 0, 1, 32'd0, 1, 0);
        drive(0, 32'h0DEC_00BE, 32'h7EBE_6FF1, "uflow1",  32'h0000_0000, 1, 1, 32'd0, 1, 0);
        drive(0, 32'hBF94_A370, 32'hFEF9_1673, "uflow2",  32'h0000_0000, 1, 1, 32'd0, 1, 0);
        drive(0, 32'h0000_0000, 32'h0000_0000, "0/0",     32'h7FC0_0000, 1, 1, 32'd0, 1, 0);
        drive(0, 32'h3F80_0000, 32'h0000_0000, "1/0",     32'h7F80_0000, 1, 1, 32'd0, 1, 0);
        drive(0, 32'h0000_0000, 32'h4000_0000, "0/2",     32'h0000_0000, 1, 1, 32'h3F00_0000, 1, 1);
        drive(0, 32'h7F00_0000, 32'h0080_0000, "huge/tiny",32'h7F80_0000, 1, 1, 32'd0, 1, 0);
        drive(0, 32'h7F80_0000, 32'h7F80_0000, "inf/inf", 32'h7FC0_0000, 1, 1, 32'd0, 1, 0);
        drive(0, 32'h4040_0000, 32'hFF80_0000, "3/-inf",  32'h8000_0000, 1, 1, 32'd0, 1, 0);
        drive(0, 32'hFF80_0000, 32'h4000_0000, "-inf/2",  32'hFF80_0000, 1, 1, 32'h3F00_0000, 1, 1);

        // reset mid-stream: the two in-flight operations are discarded
        drive(0, 32'h4040_0000, 32'h4000_0000, "drop1", 32'd0, 1, 0, 32'd0, 1, 0);
        drive(0, 32'h4040_0000, 32'h4000_0000, "drop2", 32'd0, 1, 0, 32'd0, 1, 0);
        drive(1, 32'h4040_0000, 32'h4000_0000, "mid",   32'd0, 1, 0, 32'd0, 1, 0);
        drive(0, 32'h4020_0000, 32'h4000_0000, "resume1", 32'h3FA0_0000, 1, 1, 32'h3F00_0000, 1, 1);
        drive(0, 32'hC040_0000, 32'h4000_0000, "resume2", 32'hBFC0_0000, 1, 1, 32'h3F00_0000, 1, 1);

        for (int k = 0; k < 200; k++) begin
            ra  = rnd_op();
            rb  = rnd_op();
            rye = ref_div(ra, rb, ryx);
            ric = (rb[30:23] != 8'd0) && (rb[30:23] != 8'hFF);
            rie = ref_inv(rb, rix);
            drive(0, ra, rb, "rand", rye, ryx, 1, rie, rix, ric);
        end

        drive(0, 32'd0, 32'd0, "drain", 32'd0, 1, 0, 32'd0, 1, 0);
        drive(0, 32'd0, 32'd0, "drain", 32'd0, 1, 0, 32'd0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
